fetch_controller: RTL

Sequencer for the instruction-fetch stage of the pipelined RISC-V core. It drives the enable and next-value inputs of the `program_counter` register and issues single-outstanding requests to instruction memory. It hands fetched instructions to IF/ID under downstream stall and applies branch/jump redirects from EX, including redirects that arrive while a memory request is in flight.

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/fetch_controller.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipelined RISC-V core front end.
package pipeline_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2,
      HOLD     = 2'd3
   } fetch_state_e;

   localparam int          PC_INC           = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: steers program_counter, issues single-outstanding
// imem requests, buffers the fetched word under stall and applies EX redirects.
module fetch_controller
   import pipeline_pkg::*;
#(
   parameter int            AW       = 32,
   parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] pc,
   output logic          pc_en,
   output logic [AW-1:0] pc_next,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_gnt,
   input  logic          imem_rvalid,
   input  logic [31:0]   imem_rdata,
   input  logic          stall,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   output logic          fetch_valid,
   output logic [AW-1:0] fetch_pc,
   output logic [31:0]   fetch_instr
);

   fetch_state_e  state, state_nxt;
   logic          kill, kill_nxt;
   logic [AW-1:0] kill_pc, kill_pc_nxt;
   logic [31:0]   hold_instr, hold_instr_nxt;

   logic          load;
   logic [AW-1:0] load_val;
   logic          req;
   logic          fv;
   logic [AW-1:0] fpc;
   logic [31:0]   finstr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         kill       <= 1'b0;
         kill_pc    <= '0;
         hold_instr <= '0;
      end else begin
         state      <= state_nxt;
         kill       <= kill_nxt;
         kill_pc    <= kill_pc_nxt;
         hold_instr <= hold_instr_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      kill_nxt       = kill;
      kill_pc_nxt    = kill_pc;
      hold_instr_nxt = hold_instr;
      load           = 1'b0;
      load_val       = '0;
      req            = 1'b0;
      fv             = 1'b0;
      fpc            = '0;
      finstr         = '0;
      case (state)
         IDLE: begin
            load      = 1'b1;
            load_val  = RESET_PC;
            state_nxt = REQ;
         end
         REQ: begin
            req = !redirect_valid;
            if (redirect_valid) begin
               load     = 1'b1;
               load_val = redirect_pc;
            end else if (imem_gnt) begin
               state_nxt = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            // A redirect seen while the request is in flight is remembered so the
            // stale response can be dropped; the newest target always wins.
            if (!imem_rvalid) begin
               if (redirect_valid) begin
                  kill_nxt    = 1'b1;
                  kill_pc_nxt = redirect_pc;
               end
            end else if (kill || redirect_valid) begin
               load      = 1'b1;
               load_val  = redirect_valid ? redirect_pc : kill_pc;
               kill_nxt  = 1'b0;
               state_nxt = REQ;
            end else begin
               fv     = 1'b1;
               fpc    = pc;
               finstr = imem_rdata;
               if (!stall) begin
                  load      = 1'b1;
                  load_val  = pc + AW'(PC_INC);
                  state_nxt = REQ;
               end else begin
                  hold_instr_nxt = imem_rdata;
                  state_nxt      = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               load      = 1'b1;
               load_val  = redirect_pc;
               state_nxt = REQ;
            end else begin
               fv     = 1'b1;
               fpc    = pc;
               finstr = hold_instr;
               if (!stall) begin
                  load      = 1'b1;
                  load_val  = pc + AW'(PC_INC);
                  state_nxt = REQ;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs read as their reset values while rst is held; loads are word aligned.
   assign pc_en       = !rst && load;
   assign pc_next     = (!rst && load) ? (load_val & ~AW'(3)) : '0;
   assign imem_req    = !rst && req;
   assign imem_addr   = pc;
   assign fetch_valid = !rst && fv;
   assign fetch_pc    = rst ? '0 : fpc;
   assign fetch_instr = rst ? '0 : finstr;

endmodule
